// File: rtl/fifo_arb_pkg.sv
// fifo_arb_pkg: shared types, constants and helpers for the FIFO write-port
// arbiter (fifo_wr_arbiter) and its round-robin picker (rr_arb_pick).
package fifo_arb_pkg;

   // Arbiter states: waiting for a requester, or a requester owns the port.
   typedef enum logic {
      IDLE  = 1'b0,
      BURST = 1'b1
   } arb_state_e;

   // Width of each per-requester accepted-beat statistics counter.
   localparam int STAT_W = 32;

   // Next index in circular order over n requesters (n-1 wraps to 0).
   function automatic int rr_next_idx(input int idx, input int n);
      return (idx + 1 >= n) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// rr_arb_pick: combinational round-robin picker. Returns the first requester
// after last_grant in circular order (last_grant+1, ..., wrapping), and
// whether any requester is asking at all.
module rr_arb_pick
   import fifo_arb_pkg::*;
#(
   parameter int N_REQ = 4,
   parameter int IDX_W = $clog2(N_REQ)
) (
   input  logic [N_REQ-1:0] req,
   input  logic [IDX_W-1:0] last_grant,
   output logic             any,
   output logic [IDX_W-1:0] idx
);

   // Walk the ring starting just after last_grant; the first requester found wins.
   always_comb begin
      logic             found;
      logic [IDX_W-1:0] cand;
      // NOTE: every variable gets a value before any branch, so no path leaves
      // one unassigned and no latch is inferred.
      any   = |req;
      idx   = '0;
      found = 1'b0;
      cand  = last_grant;
      for (int k = 0; k < N_REQ; k++) begin
         cand = IDX_W'(rr_next_idx(int'(cand), N_REQ));
         if (!found && req[cand]) begin
            idx   = cand;
            found = 1'b1;
         end
      end
   end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: shares the single write port of a FWFT FIFO between N_REQ
// stream requesters. Grants are round-robin and held until the winner sends a
// last beat or reaches MAX_BURST beats. Writes are never issued while the FIFO
// reports full.
// Optional feature: define FIFO_ARB_STATS_EN to build the per-requester
// accepted-beat counters; otherwise stat_beats reads 0 and stat_clr is ignored.
module fifo_wr_arbiter
   import fifo_arb_pkg::*;
#(
   parameter int N_REQ     = 4,
   parameter int DATA_W    = 32,
   parameter int MAX_BURST = 16
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [N_REQ-1:0]           req_valid,
   input  logic [N_REQ*DATA_W-1:0]    req_data,
   input  logic [N_REQ-1:0]           req_last,
   output logic [N_REQ-1:0]           req_ready,
   output logic                       fifo_wr_en,
   output logic [DATA_W-1:0]          fifo_din,
   input  logic                       fifo_full,
   output logic                       grant_active,
   output logic [$clog2(N_REQ)-1:0]   grant_id,
   input  logic                       stat_clr,
   output logic [N_REQ*STAT_W-1:0]    stat_beats
);

   localparam int                IDX_W    = $clog2(N_REQ);
   localparam int                CNT_W    = $clog2(MAX_BURST + 1);
   localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(MAX_BURST);
   localparam logic [IDX_W-1:0]  LAST_RST = IDX_W'(N_REQ - 1);

   arb_state_e         state_q, state_d;
   logic [IDX_W-1:0]   grant_id_q, grant_id_d;
   logic [IDX_W-1:0]   last_grant_q, last_grant_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;

   logic               pick_any;
   logic [IDX_W-1:0]   pick_idx;
   logic [DATA_W-1:0]  data_arr [N_REQ];

   rr_arb_pick #(
      .N_REQ (N_REQ),
      .IDX_W (IDX_W)
   ) u_pick (
      .req        (req_valid),
      .last_grant (last_grant_q),
      .any        (pick_any),
      .idx        (pick_idx)
   );

   // Grantee's handshake and data mux; fifo_full gates ready and write directly.
   always_comb begin
      for (int i = 0; i < N_REQ; i++) begin
         data_arr[i] = req_data[i*DATA_W +: DATA_W];
      end
      req_ready  = '0;
      fifo_wr_en = 1'b0;
      fifo_din   = data_arr[grant_id_q];
      if (state_q == BURST && !fifo_full) begin
         req_ready[grant_id_q] = 1'b1;
         fifo_wr_en            = req_valid[grant_id_q];
      end
   end

   assign grant_active = (state_q == BURST);
   assign grant_id     = grant_id_q;

   // Arbitrate in IDLE; in BURST count accepted beats and release on last/MAX_BURST.
   always_comb begin
      state_d      = state_q;
      grant_id_d   = grant_id_q;
      last_grant_d = last_grant_q;
      cnt_d        = cnt_q;
      unique case (state_q)
         IDLE: begin
            if (pick_any) begin
               grant_id_d = pick_idx;
               cnt_d      = '0;
               state_d    = BURST;
            end
         end
         BURST: begin
            if (fifo_wr_en) begin
               cnt_d = cnt_q + CNT_W'(1);
               if (req_last[grant_id_q] || (cnt_q + CNT_W'(1)) == CNT_MAX) begin
                  last_grant_d = grant_id_q;
                  state_d      = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Control registers with synchronous active-low reset; requester 0 wins first.
   always_ff @(posedge clk) begin
      // NOTE: state registers use non-blocking assignments so every flop
      // samples the pre-edge values, independent of statement order.
      if (!rst_n) begin
         state_q      <= IDLE;
         grant_id_q   <= '0;
         last_grant_q <= LAST_RST;
         cnt_q        <= '0;
      end else begin
         state_q      <= state_d;
         grant_id_q   <= grant_id_d;
         last_grant_q <= last_grant_d;
         cnt_q        <= cnt_d;
      end
   end

`ifdef FIFO_ARB_STATS_EN
   logic [STAT_W-1:0] stat_q [N_REQ];
   logic [STAT_W-1:0] stat_d [N_REQ];

   // Clear wins over a same-cycle increment; counters wrap at 2^STAT_W.
   always_comb begin
      stat_d = stat_q;
      if (stat_clr) begin
         for (int i = 0; i < N_REQ; i++) begin
            stat_d[i] = '0;
         end
      end else if (fifo_wr_en) begin
         stat_d[grant_id_q] = stat_q[grant_id_q] + STAT_W'(1);
      end
   end

   // Statistics counters.
   always_ff @(posedge clk) begin
      // NOTE: this array is a handful of counters built from flops, not a RAM,
      // so resetting every entry is cheap and keeps the outputs defined.
      if (!rst_n) begin
         for (int i = 0; i < N_REQ; i++) begin
            stat_q[i] <= '0;
         end
      end else begin
         stat_q <= stat_d;
      end
   end

   // Flatten the counters onto the output bus.
   always_comb begin
      stat_beats = '0;
      for (int i = 0; i < N_REQ; i++) begin
         stat_beats[i*STAT_W +: STAT_W] = stat_q[i];
      end
   end
`else
   logic stat_clr_unused;
   assign stat_clr_unused = stat_clr;
   assign stat_beats      = '0;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: directed test-plan scenarios plus randomized traffic,
// all checked cycle by cycle against a transaction-level reference model.
module tb_fifo_wr_arbiter;

   localparam int N    = 4;
   localparam int DW   = 32;
   localparam int MAXB = 4;

   logic              clk = 1'b0;
   logic              rst_n;
   logic [N-1:0]      req_valid;
   logic [N*DW-1:0]   req_data;
   logic [N-1:0]      req_last;
   logic [N-1:0]      req_ready;
   logic              fifo_wr_en;
   logic [DW-1:0]     fifo_din;
   logic              fifo_full;
   logic              grant_active;
   logic [1:0]        grant_id;
   logic              stat_clr;
   logic [N*32-1:0]   stat_beats;

   always #5 clk = ~clk;

   fifo_wr_arbiter #(.N_REQ(N), .DATA_W(DW), .MAX_BURST(MAXB)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .req_valid    (req_valid),
      .req_data     (req_data),
      .req_last     (req_last),
      .req_ready    (req_ready),
      .fifo_wr_en   (fifo_wr_en),
      .fifo_din     (fifo_din),
      .fifo_full    (fifo_full),
      .grant_active (grant_active),
      .grant_id     (grant_id),
      .stat_clr     (stat_clr),
      .stat_beats   (stat_beats)
   );

   typedef struct {
      logic [31:0] data;
      logic        last;
   } beat_t;

   // Pending beats per requester; the head is presented while en[i] is set.
   beat_t       src_q [N][$];
   bit          en [N];

   int          n_vec = 0;
   int          n_bad = 0;
   int          cyc   = 0;

   // Reference model: owner of the port (-1 when none), last owner, shown id.
   int          m_owner;
   int          m_last;
   int          m_gid;
   int          m_cnt;
   logic [31:0] m_stat [N];

   logic        obs_wr;
   logic [N-1:0] obs_ready;
   int          lg_src [$];
   int          lg_cyc [$];
   logic [31:0] lg_dat [$];

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic model_reset();
      m_owner = -1;
      m_last  = N - 1;
      m_gid   = 0;
      m_cnt   = 0;
      for (int i = 0; i < N; i++) m_stat[i] = '0;
   endtask

   function automatic int pending();
      int s = 0;
      for (int i = 0; i < N; i++) s += src_q[i].size();
      return s;
   endfunction

   task automatic push_beat(input int r, input logic [31:0] d, input logic l);
      beat_t b;
      b.data = d;
      b.last = l;
      src_q[r].push_back(b);
   endtask

   task automatic clear_log();
      lg_src.delete();
      lg_cyc.delete();
      lg_dat.delete();
   endtask

   // One clock: drive, compare at negedge, then advance the model at posedge.
   task automatic step();
      logic         exp_act;
      logic [N-1:0] exp_rdy;
      logic         exp_wr;
      int           own;
      beat_t        b;
      for (int i = 0; i < N; i++) begin
         req_valid[i] = en[i] && (src_q[i].size() > 0);
         req_data[i*DW +: DW] = (src_q[i].size() > 0) ? src_q[i][0].data : 32'h0;
         req_last[i]  = (src_q[i].size() > 0) ? src_q[i][0].last : 1'b0;
      end
      @(negedge clk);
      own     = m_owner;
      exp_act = (own >= 0);
      exp_rdy = '0;
      exp_wr  = 1'b0;
      if (exp_act && !fifo_full) begin
         exp_rdy[own] = 1'b1;
         exp_wr       = req_valid[own];
      end
      check("grant_active", 64'(grant_active), 64'(exp_act));
      check("req_ready", 64'(req_ready), 64'(exp_rdy));
      check("fifo_wr_en", 64'(fifo_wr_en), 64'(exp_wr));
      check("grant_id", 64'(grant_id), 64'(m_gid));
      if (exp_wr) check("fifo_din", 64'(fifo_din), 64'(src_q[own][0].data));
      for (int i = 0; i < N; i++) check("stat_beats", 64'(stat_beats[i*32 +: 32]), 64'(m_stat[i]));
      obs_wr    = fifo_wr_en;
      obs_ready = req_ready;
      if (fifo_wr_en) begin
         lg_src.push_back(int'(grant_id));
         lg_dat.push_back(fifo_din);
         lg_cyc.push_back(cyc);
      end
      @(posedge clk);
      b.last = 1'b0;
      if (exp_wr) b = src_q[own].pop_front();
      if (!rst_n) begin
         model_reset();
      end else begin
`ifdef FIFO_ARB_STATS_EN
         if (stat_clr) begin
            for (int i = 0; i < N; i++) m_stat[i] = '0;
         end else if (exp_wr) begin
            m_stat[own] = m_stat[own] + 32'd1;
         end
`endif
         if (own < 0) begin
            for (int k = 1; k <= N; k++) begin
               int j = (m_last + k) % N;
               if (m_owner < 0 && req_valid[j]) begin
                  m_owner = j;
                  m_gid   = j;
                  m_cnt   = 0;
               end
            end
         end else if (exp_wr) begin
            m_cnt++;
            if (b.last || m_cnt == MAXB) begin
               m_last  = own;
               m_owner = -1;
            end
         end
      end
      cyc++;
      #1;
   endtask

   task automatic drain(input int max_cyc);
      int k = 0;
      while (pending() > 0 && k < max_cyc) begin
         step();
         k++;
      end
      check("drain_timeout", 64'(pending()), 64'd0);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int t0;
      rst_n     = 1'b0;
      req_valid = '0;
      req_data  = '0;
      req_last  = '0;
      fifo_full = 1'b0;
      stat_clr  = 1'b0;
      for (int i = 0; i < N; i++) en[i] = 1'b1;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Reset state.
      do_reset();
      check("rst_active", 64'(grant_active), 64'd0);
      check("rst_id", 64'(grant_id), 64'd0);
      check("rst_ready", 64'(req_ready), 64'd0);
      check("rst_wr", 64'(fifo_wr_en), 64'd0);

      // Single requester, 3 beats: ready one cycle after valid, back-to-back writes.
      clear_log();
      for (int k = 0; k < 3; k++) push_beat(0, 32'hA0 + 32'(k), k == 2);
      t0 = cyc;
      drain(20);
      check("t1_count", 64'(lg_dat.size()), 64'd3);
      for (int k = 0; k < 3 && k < lg_dat.size(); k++) begin
         check("t1_data", 64'(lg_dat[k]), 64'(32'hA0 + 32'(k)));
         check("t1_src", 64'(lg_src[k]), 64'd0);
         check("t1_cycle", 64'(lg_cyc[k]), 64'(t0 + 1 + k));
      end
      step();
      check("t1_released", 64'(grant_active), 64'd0);

      // Fairness: all four valid with 1-beat packets, two rounds.
      do_reset();
      clear_log();
      for (int p = 0; p < 2; p++)
         for (int r = 0; r < N; r++) push_beat(r, 32'h100 * 32'(r) + 32'(p), 1'b1);
      drain(40);
      check("t2_count", 64'(lg_dat.size()), 64'd8);
      for (int k = 0; k < 8 && k < lg_dat.size(); k++) begin
         check("t2_order", 64'(lg_src[k]), 64'(k % N));
         check("t2_data", 64'(lg_dat[k]), 64'(32'h100 * 32'(k % N) + 32'(k / N)));
         if (k > 0) check("t2_bubble", 64'(lg_cyc[k] - lg_cyc[k-1]), 64'd2);
      end
`ifdef FIFO_ARB_STATS_EN
      for (int i = 0; i < N; i++) check("t2_stats", 64'(stat_beats[i*32 +: 32]), 64'd2);
`else
      for (int i = 0; i < N; i++) check("t2_stats_off", 64'(stat_beats[i*32 +: 32]), 64'd0);
`endif

      // 10-beat packet split 4/4/2 by MAX_BURST with one-cycle bubbles.
      clear_log();
      for (int k = 0; k < 10; k++) push_beat(2, 32'hC0 + 32'(k), k == 9);
      drain(40);
      check("t3_count", 64'(lg_dat.size()), 64'd10);
      for (int k = 0; k < 10 && k < lg_dat.size(); k++) begin
         check("t3_data", 64'(lg_dat[k]), 64'(32'hC0 + 32'(k)));
         check("t3_src", 64'(lg_src[k]), 64'd2);
         if (k > 0) check("t3_gap", 64'(lg_cyc[k] - lg_cyc[k-1]), (k % MAXB == 0) ? 64'd2 : 64'd1);
      end

      // FIFO full for 5 cycles mid-burst.
      clear_log();
      for (int k = 0; k < 4; k++) push_beat(1, 32'hD0 + 32'(k), k == 3);
      repeat (3) step();
      fifo_full = 1'b1;
      repeat (5) begin
         step();
         check("t4_stall_wr", 64'(obs_wr), 64'd0);
         check("t4_stall_ready", 64'(obs_ready), 64'd0);
      end
      fifo_full = 1'b0;
      drain(20);
      check("t4_count", 64'(lg_dat.size()), 64'd4);
      for (int k = 0; k < 4 && k < lg_dat.size(); k++)
         check("t4_data", 64'(lg_dat[k]), 64'(32'hD0 + 32'(k)));
      if (lg_cyc.size() >= 3) check("t4_resume", 64'(lg_cyc[2] - lg_cyc[1]), 64'd6);

      // Reset after beat 2 of 5; requester 0 then wins over requester 3.
      for (int k = 0; k < 5; k++) push_beat(3, 32'hE0 + 32'(k), k == 4);
      repeat (3) step();
      en[3] = 1'b0;
      do_reset();
      en[3] = 1'b1;
      check("t5_active", 64'(grant_active), 64'd0);
      check("t5_id", 64'(grant_id), 64'd0);
      check("t5_ready", 64'(req_ready), 64'd0);
      check("t5_wr", 64'(fifo_wr_en), 64'd0);
      push_beat(0, 32'hF0, 1'b1);
      clear_log();
      drain(40);
      check("t5_count", 64'(lg_dat.size()), 64'd4);
      if (lg_src.size() > 0) check("t5_first", 64'(lg_src[0]), 64'd0);

      // Statistics clear coinciding with an accepted beat.
      push_beat(0, 32'h11, 1'b0);
      push_beat(0, 32'h12, 1'b1);
      step();
      stat_clr = 1'b1;
      step();
      stat_clr = 1'b0;
`ifdef FIFO_ARB_STATS_EN
      check("t6_clr", 64'(stat_beats[31:0]), 64'd0);
      step();
      check("t6_after", 64'(stat_beats[31:0]), 64'd1);
`else
      check("t6_off", 64'(stat_beats), 64'd0);
      step();
`endif

      // Randomized traffic with stalls, dropped valids, clears and resets.
      for (int c = 0; c < 3000; c++) begin
         for (int i = 0; i < N; i++) begin
            if (src_q[i].size() < 3 && $urandom_range(3) == 0) begin
               int len = int'($urandom_range(6, 1));
               for (int k = 0; k < len; k++) push_beat(i, $urandom, k == len - 1);
            end
            en[i] = ($urandom_range(7) != 0);
         end
         fifo_full = ($urandom_range(4) == 0);
         stat_clr  = ($urandom_range(49) == 0);
         rst_n     = ($urandom_range(399) != 0);
         step();
      end
      rst_n     = 1'b1;
      stat_clr  = 1'b0;
      fifo_full = 1'b0;
      for (int i = 0; i < N; i++) en[i] = 1'b1;
      drain(300);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

- Shares the single write port of the BRAM FWFT FIFO between `N_REQ` stream requesters in the DMA subsystem, such as per-channel read-data returns.
- Grants are round-robin and burst-locked: a winner keeps the port until it sends a `last` beat or reaches `MAX_BURST` beats.
- Never drives a write into a full FIFO, so no data is ever dropped.
- Sits between the channel stream sources and the FIFO's `wr_en`/`din`/`full` pins.

## Interface
- `N_REQ`, 4, number of requesters (2..16)
- `DATA_W`, 32, data width; must match the FIFO
- `MAX_BURST`, 16, maximum beats per grant (≥1); forces re-arbitration
- `clk` in 1: single clock, rising edge
- `rst_n` in 1: reset, synchronous, active-low
- `req_valid` in N_REQ: per-requester beat valid
- `req_data` in N_REQ*DATA_W: requester i occupies bits [i*DATA_W +: DATA_W]
- `req_last` in N_REQ: final beat of the requester's packet
- `req_ready` out N_REQ: one-hot or zero; beat accepted when valid&&ready
- `fifo_wr_en` out 1: to FIFO `wr_en`
- `fifo_din` out DATA_W: to FIFO `din`
- `fifo_full` in 1: from FIFO `full`
- `grant_active` out 1: a requester currently holds the port
- `grant_id` out $clog2(N_REQ): current or most recent grantee
- `stat_clr` in 1: clears statistics counters
- `stat_beats` out N_REQ*32: per-requester accepted-beat counters

## Operation
- Two states: `IDLE` and `BURST`.
- **IDLE**
  - If any `req_valid` is high, pick the first requester after `last_grant` in circular order (`last_grant+1` … wrapping).
  - Register the pick into `grant_id`, load beat count 0, set `grant_active` and go to `BURST`.
  - If no `req_valid` is high, stay in `IDLE`.
- **BURST**
  - `req_ready[grant_id] = !fifo_full`; all other ready bits are 0.
  - `fifo_wr_en = req_valid[grant_id] && !fifo_full`.
  - `fifo_din = req_data[grant_id]` (combinational mux).
  - Each accepted beat increments the beat count.
- **Release:** on an accepted beat with `req_last`, or on the accepted beat that makes the count equal `MAX_BURST`:
  - update `last_grant <= grant_id`;
  - clear `grant_active`;
  - go to `IDLE`.
- **Truncated packet:** if `MAX_BURST` truncates a packet, the requester re-arbitrates for the remainder. `last` framing is the requester's concern.
- **Valid dropped mid-burst:** the grant is held and no write is issued. There is no timeout.
- **FIFO full:** ready and wr_en are held low. The grant is held and the beat count does not change.
- **Beat counter:** width $clog2(MAX_BURST+1). It cannot overflow because release occurs at `MAX_BURST`.
- **Reset:** `req_ready=0`, `fifo_wr_en=0`, `grant_active=0`, `grant_id=0`, `last_grant=N_REQ-1` (so requester 0 wins first), state `IDLE`, `stat_beats=0`.
  - Reset mid-burst discards the grant.
  - Beats already written to the FIFO remain in it; the FIFO has its own reset.

## Timing
- Arbitration latency: a `req_valid` rising in cycle t while in `IDLE` gives `req_ready` in cycle t+1. The first write is possible in t+1.
- Release costs one `IDLE` bubble cycle. Back-to-back grants are therefore spaced by exactly 1 cycle.
- Throughput within a burst is 1 beat/cycle while `fifo_full` is low.
- `fifo_wr_en` and `req_ready` depend combinationally on `fifo_full`, which is a registered count compare in the FIFO, so there is no loop.
- `fifo_din` is valid whenever `fifo_wr_en` is high.

## Configuration
- Macro: `FIFO_ARB_STATS_EN`.
- **Defined:**
  - `stat_beats[i]` increments on every beat accepted from requester i, wrapping at 2^32.
  - `stat_clr` zeroes all counters next cycle; `stat_clr` has priority over an increment in the same cycle.
- **Undefined:** the ports still exist, `stat_beats` is tied to 0, `stat_clr` is ignored, and no counter flops are present.

## Structure
- **`fifo_arb_pkg`:**
  - state enum `arb_state_e {IDLE, BURST}`;
  - `STAT_W = 32`;
  - function `rr_next_idx`.
- **Sub-module `rr_arb_pick`:** combinational round-robin picker.
  - Inputs: request vector, `last_grant`.
  - Outputs: `any`, `idx`.
  - Instantiated once in `fifo_wr_arbiter`.

## Test plan
- **Single requester:** req 0 sends 3 beats (`last` on the 3rd) with `fifo_full=0`.
  - Ready rises 1 cycle after valid.
  - 3 consecutive `fifo_wr_en` pulses with data 0xA0, 0xA1, 0xA2.
  - `grant_active` falls after the 3rd beat.
- **Fairness:** all 4 requesters continuously valid with 1-beat packets.
  - Grant order 0,1,2,3,0,1…
  - One bubble between grants.
- **MAX_BURST=4:** req 2 sends a 10-beat packet with no competitors.
  - Grants of 4, 4, 2 beats, separated by 1-cycle `IDLE` bubbles.
  - All 10 beats appear in order.
- **Full stall:** assert `fifo_full` for 5 cycles mid-burst.
  - `fifo_wr_en=0` and ready=0 for those 5 cycles.
  - No data lost; the burst resumes with the next beat.
- **Reset mid-burst:** drive `rst_n=0` for 1 cycle after beat 2 of 5.
  - All outputs reset next edge.
  - Requester 0 wins the next arbitration.
- **Stats (`FIFO_ARB_STATS_EN`):**
  - After the fairness test runs 8 grants, `stat_beats` = 2,2,2,2.
  - `stat_clr` with a simultaneous beat → that counter is 0.
